// File: rtl/gemm_loop_ctrl.sv
// -----------------------------------------------------------------------------
// gemm_loop_ctrl
//
// Purpose:
//   Upstream sequencer for the GEMM index decoder. Accepts one 128-bit GEMM
//   instruction and walks its loop nest: outer index i0 over iter_out, inner
//   index i1 over iter_in, and a micro-op address sweep from uop_bgn up to
//   uop_end-1. Every beat carries one uop address plus six tensor offsets.
//   The offsets are kept as running sums, one add per wrap, so no multiplier
//   is needed.
//
// Configuration macro:
//   GEMM_PERF_CNT_EN - when defined, adds perf_uop_cnt (accepted beats) and
//                      perf_stall_cnt (out_valid & !out_ready cycles). Both are
//                      cleared when an insn is accepted and saturate at all-ones.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   insn[127:0], insn_valid  instruction offer
//   insn_ready               high only while idle
//   out_valid, out_ready     beat handshake
//   uop_addr                 micro-op memory address
//   {dst,src,wgt}_offset_*   tensor offsets for the outer/inner loop index
//   out_reset                reset_reg bit of the current insn
//   out_last                 marks the final beat of the insn
//   done                     one-cycle pulse after the final beat is accepted
//   perf_uop_cnt, perf_stall_cnt  (GEMM_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module gemm_loop_ctrl #(
    parameter int UOP_ADDR_W = 13,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          insn,
    input  logic                  insn_valid,
    output logic                  insn_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [UOP_ADDR_W-1:0] uop_addr,
    output logic [10:0]           dst_offset_out,
    output logic [10:0]           dst_offset_in,
    output logic [10:0]           src_offset_out,
    output logic [10:0]           src_offset_in,
    output logic [9:0]            wgt_offset_out,
    output logic [9:0]            wgt_offset_in,
    output logic                  out_reset,
    output logic                  out_last,
`ifdef GEMM_PERF_CNT_EN
    output logic [PERF_W-1:0]     perf_uop_cnt,
    output logic [PERF_W-1:0]     perf_stall_cnt,
`endif
    output logic                  done
);

    localparam int END_W = UOP_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Instruction field decode
    logic [UOP_ADDR_W-1:0] f_uop_bgn;
    logic [END_W-1:0]      f_uop_end;
    logic [13:0]           f_iter_out, f_iter_in;
    logic                  f_empty, f_single;

    assign f_uop_bgn  = insn[20:8];
    assign f_uop_end  = insn[34:21];
    assign f_iter_out = insn[48:35];
    assign f_iter_in  = insn[62:49];

    // Bits outside any field are intentionally ignored
    logic unused_insn_bits;
    assign unused_insn_bits = ^{insn[127], insn[6:0]};

    assign f_empty  = (f_iter_out == 14'd0) || (f_iter_in == 14'd0) ||
                      (f_uop_end <= {1'b0, f_uop_bgn});
    // A one-beat insn is already on its last beat when the first beat appears
    assign f_single = (f_iter_out == 14'd1) && (f_iter_in == 14'd1) &&
                      (f_uop_end == {1'b0, f_uop_bgn} + END_W'(1));

    // Latched loop bounds and strides
    logic [UOP_ADDR_W-1:0] uop_bgn_r;
    logic [END_W-1:0]      uop_end_r;
    logic [13:0]           iter_out_r, iter_in_r;
    logic [10:0]           dst_f_out_r, dst_f_in_r, src_f_out_r, src_f_in_r;
    logic [9:0]            wgt_f_out_r, wgt_f_in_r;
    logic [13:0]           i0, i1;

    // Next-beat values, used only when the current beat is accepted
    logic [UOP_ADDR_W-1:0] uop_nx;
    logic [13:0]           i0_nx, i1_nx;
    logic [10:0]           dst_o_nx, dst_i_nx, src_o_nx, src_i_nx;
    logic [9:0]            wgt_o_nx, wgt_i_nx;
    logic                  uop_wrap, i1_wrap, last_nx;

    always_comb begin
        uop_wrap = ({1'b0, uop_addr} == uop_end_r - END_W'(1));
        i1_wrap  = (i1 == iter_in_r - 14'd1);
        uop_nx   = uop_addr + UOP_ADDR_W'(1);
        i0_nx    = i0;
        i1_nx    = i1;
        dst_o_nx = dst_offset_out;
        dst_i_nx = dst_offset_in;
        src_o_nx = src_offset_out;
        src_i_nx = src_offset_in;
        wgt_o_nx = wgt_offset_out;
        wgt_i_nx = wgt_offset_in;
        if (uop_wrap) begin
            uop_nx = uop_bgn_r;
            if (i1_wrap) begin
                i1_nx    = 14'd0;
                dst_i_nx = 11'd0;
                src_i_nx = 11'd0;
                wgt_i_nx = 10'd0;
                i0_nx    = i0 + 14'd1;
                dst_o_nx = dst_offset_out + dst_f_out_r;
                src_o_nx = src_offset_out + src_f_out_r;
                wgt_o_nx = wgt_offset_out + wgt_f_out_r;
            end else begin
                i1_nx    = i1 + 14'd1;
                dst_i_nx = dst_offset_in + dst_f_in_r;
                src_i_nx = src_offset_in + src_f_in_r;
                wgt_i_nx = wgt_offset_in + wgt_f_in_r;
            end
        end
        last_nx = ({1'b0, uop_nx} == uop_end_r - END_W'(1)) &&
                  (i1_nx == iter_in_r - 14'd1) &&
                  (i0_nx == iter_out_r - 14'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            insn_ready     <= 1'b1;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_reset      <= 1'b0;
            done           <= 1'b0;
            uop_addr       <= '0;
            dst_offset_out <= '0;
            dst_offset_in  <= '0;
            src_offset_out <= '0;
            src_offset_in  <= '0;
            wgt_offset_out <= '0;
            wgt_offset_in  <= '0;
            uop_bgn_r      <= '0;
            uop_end_r      <= '0;
            iter_out_r     <= '0;
            iter_in_r      <= '0;
            dst_f_out_r    <= '0;
            dst_f_in_r     <= '0;
            src_f_out_r    <= '0;
            src_f_in_r     <= '0;
            wgt_f_out_r    <= '0;
            wgt_f_in_r     <= '0;
            i0             <= '0;
            i1             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (insn_valid && insn_ready) begin
                        insn_ready     <= 1'b0;
                        uop_bgn_r      <= f_uop_bgn;
                        uop_end_r      <= f_uop_end;
                        iter_out_r     <= f_iter_out;
                        iter_in_r      <= f_iter_in;
                        dst_f_out_r    <= insn[73:63];
                        dst_f_in_r     <= insn[84:74];
                        src_f_out_r    <= insn[95:85];
                        src_f_in_r     <= insn[106:96];
                        wgt_f_out_r    <= insn[116:107];
                        wgt_f_in_r     <= insn[126:117];
                        out_reset      <= insn[7];
                        i0             <= '0;
                        i1             <= '0;
                        uop_addr       <= f_uop_bgn;
                        dst_offset_out <= '0;
                        dst_offset_in  <= '0;
                        src_offset_out <= '0;
                        src_offset_in  <= '0;
                        wgt_offset_out <= '0;
                        wgt_offset_in  <= '0;
                        if (f_empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                            out_last  <= f_single;
                        end
                    end
                end
                RUN: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            uop_addr       <= uop_nx;
                            i0             <= i0_nx;
                            i1             <= i1_nx;
                            dst_offset_out <= dst_o_nx;
                            dst_offset_in  <= dst_i_nx;
                            src_offset_out <= src_o_nx;
                            src_offset_in  <= src_i_nx;
                            wgt_offset_out <= wgt_o_nx;
                            wgt_offset_in  <= wgt_i_nx;
                            out_last       <= last_nx;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    state      <= IDLE;
                    insn_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    insn_ready <= 1'b1;
                    out_valid  <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef GEMM_PERF_CNT_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_uop_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else if (state == IDLE && insn_valid && insn_ready) begin
            perf_uop_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else if (out_valid) begin
            if (out_ready) perf_uop_cnt   <= sat_inc(perf_uop_cnt);
            else           perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_gemm_loop_ctrl.sv
module tb_gemm_loop_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] insn = '0;
    logic         insn_valid = 1'b0;
    logic         insn_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [12:0]  uop_addr;
    logic [10:0]  dst_offset_out, dst_offset_in, src_offset_out, src_offset_in;
    logic [9:0]   wgt_offset_out, wgt_offset_in;
    logic         out_reset, out_last, done;
`ifdef GEMM_PERF_CNT_EN
    logic [31:0]  perf_uop_cnt, perf_stall_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    gemm_loop_ctrl dut (
        .clk(clk), .rst(rst), .insn(insn), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .out_valid(out_valid), .out_ready(out_ready),
        .uop_addr(uop_addr),
        .dst_offset_out(dst_offset_out), .dst_offset_in(dst_offset_in),
        .src_offset_out(src_offset_out), .src_offset_in(src_offset_in),
        .wgt_offset_out(wgt_offset_out), .wgt_offset_in(wgt_offset_in),
        .out_reset(out_reset), .out_last(out_last),
`ifdef GEMM_PERF_CNT_EN
        .perf_uop_cnt(perf_uop_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] mk_insn(input int bgn, input int en, input int io,
                                             input int ii, input int dfo, input int dfi,
                                             input int sfo, input int sfi, input int wfo,
                                             input int wfi, input bit rr);
        logic [127:0] v;
        v = '0;
        v[20:8]    = 13'(bgn);
        v[34:21]   = 14'(en);
        v[48:35]   = 14'(io);
        v[62:49]   = 14'(ii);
        v[73:63]   = 11'(dfo);
        v[84:74]   = 11'(dfi);
        v[95:85]   = 11'(sfo);
        v[106:96]  = 11'(sfi);
        v[116:107] = 10'(wfo);
        v[126:117] = 10'(wfi);
        v[7]       = rr;
        return v;
    endfunction

    function automatic logic [127:0] dut_beat();
        return {49'd0, uop_addr, dst_offset_out, dst_offset_in, src_offset_out,
                src_offset_in, wgt_offset_out, wgt_offset_in, out_reset, out_last};
    endfunction

    // Reference: offsets are index*stride reduced modulo the port width
    task automatic build_model(input logic [127:0] ins, output logic [127:0] q[$]);
        int bgn, en, io, ii;
        logic [127:0] b;
        bgn = int'(ins[20:8]);  en = int'(ins[34:21]);
        io  = int'(ins[48:35]); ii = int'(ins[62:49]);
        q = {};
        for (int a = 0; a < io; a++)
            for (int c = 0; c < ii; c++)
                for (int u = bgn; u < en; u++) begin
                    b = {49'd0, 13'(u),
                         11'((a * int'(ins[73:63])) % 2048),
                         11'((c * int'(ins[84:74])) % 2048),
                         11'((a * int'(ins[95:85])) % 2048),
                         11'((c * int'(ins[106:96])) % 2048),
                         10'((a * int'(ins[116:107])) % 1024),
                         10'((c * int'(ins[126:117])) % 1024),
                         ins[7],
                         1'((a == io - 1) && (c == ii - 1) && (u == en - 1))};
                    q.push_back(b);
                end
    endtask

    // mode 0: always ready, 1: random ready, 2: first five valid cycles stalled
    task automatic run_insn(input logic [127:0] ins, input int mode);
        logic [127:0] exp_q[$];
        int idx, cyc, stalls;
        bit fin, rdy;
        build_model(ins, exp_q);
        idx = 0; cyc = 0; stalls = 0; fin = 0;
        check("ready_before_accept", insn_ready, 1'b1);
        insn = ins; insn_valid = 1'b1;
        @(posedge clk); #1;
        insn_valid = 1'b0;
        insn = 128'(({$urandom, $urandom, $urandom, $urandom}));
        while (!fin && cyc < 2000) begin
            cyc++;
            check("busy_not_ready", insn_ready, 1'b0);
            if (done) begin
                check("beats_at_done", idx, exp_q.size());
                check("valid_at_done", out_valid, 1'b0);
                if (exp_q.size() == 0) check("empty_done_latency", cyc, 1);
                fin = 1;
            end else begin
                check("valid_in_run", out_valid, 1'b1);
                if (mode == 0)      rdy = 1'b1;
                else if (mode == 1) rdy = 1'($urandom_range(0, 1));
                else                rdy = (stalls >= 5);
                if (idx < exp_q.size()) check("beat", dut_beat(), exp_q[idx]);
                else                    check("extra_beat", 1'b1, 1'b0);
                if (rdy) idx++; else stalls++;
                out_ready = rdy;
            end
            @(posedge clk); #1;
        end
        if (!fin) check("timeout_waiting_done", 1'b0, 1'b1);
        out_ready = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("ready_after_done", insn_ready, 1'b1);
`ifdef GEMM_PERF_CNT_EN
        check("perf_uop_cnt", perf_uop_cnt, exp_q.size());
        check("perf_stall_cnt", perf_stall_cnt, stalls);
`endif
    endtask

    logic [127:0] spec_insn;

    initial begin
        spec_insn = mk_insn(4, 6, 2, 3, 16, 1, 0, 0, 0, 0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_insn_ready", insn_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_beat", dut_beat(), 128'd0);

        // Main loop nest with different backpressure patterns
        run_insn(spec_insn, 0);
        run_insn(spec_insn, 1);
        run_insn(spec_insn, 2);

        // Empty instructions
        run_insn(mk_insn(4, 6, 2, 0, 16, 1, 0, 0, 0, 0, 1'b0), 0);
        run_insn(mk_insn(7, 7, 2, 3, 16, 1, 0, 0, 0, 0, 1'b0), 0);
        run_insn(mk_insn(9, 5, 2, 3, 16, 1, 0, 0, 0, 0, 1'b1), 0);
        run_insn(mk_insn(4, 6, 0, 3, 16, 1, 0, 0, 0, 0, 1'b0), 0);

        // Offset wrap modulo port width
        run_insn(mk_insn(0, 1, 3, 1, 2000, 0, 1500, 0, 1000, 0, 1'b1), 0);

        // Reset in the middle of a run
        insn = spec_insn; insn_valid = 1'b1;
        @(posedge clk); #1;
        insn_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_uop", uop_addr, 13'd4);
        check("pre_rst_dst_in", dst_offset_in, 11'd1);
        rst = 1'b1; #1;
        check("midrst_insn_ready", insn_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_beat", dut_beat(), 128'd0);
        @(posedge clk); #1;
        check("midrst_no_done", done, 1'b0);
        rst = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("after_rst_no_done", done, 1'b0);
        check("after_rst_idle", out_valid, 1'b0);
        run_insn(mk_insn(0, 1, 1, 1, 5, 6, 7, 8, 9, 10, 1'b0), 0);

        // Randomized instructions against the reference
        for (int n = 0; n < 20; n++) begin
            int b;
            b = int'($urandom_range(0, 8000));
            run_insn(mk_insn(b, b + int'($urandom_range(0, 4)),
                             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                             int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                             int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                             1'($urandom_range(0, 1))), 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
